xgemac_wb_arbiter: RTL

XGEMAC_WB_ARBITER -- requirements
Module: xgemac_wb_arbiter

---
 rtl/xgemac_wb_pkg.sv | 26 ++
 rtl/xgemac_rr_arb2.sv | 28 ++
 rtl/xgemac_wb_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/xgemac_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xgemac_wb_pkg
// Purpose  : Shared definitions for the XGEMAC Wishbone arbiter slice:
//            bus width defaults, ack timeout default, wait-counter width
//            and the arbiter FSM state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package xgemac_wb_pkg;

   localparam int WB_ADDR_WIDTH = 8;
   localparam int WB_DATA_WIDTH = 32;
   localparam int WB_TIMEOUT    = 16;

   // Wide enough for the largest legal TIMEOUT (255).
   localparam int WB_CNT_W      = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CYCLE = 2'd1,
      ST_RESP  = 2'd2
   } wb_state_t;

endpackage : xgemac_wb_pkg
`default_nettype wire

// File: rtl/xgemac_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : xgemac_rr_arb2
// Purpose  : Two-way round-robin grant. A lone request always wins; when
//            both request, the one that was not granted last wins.
// Ports    : req_i   [1:0] in  - request vector (bit n = requester n)
//            last_i        in  - index of the requester granted last
//            grant_o [1:0] out - one-hot grant (zero when no request)
// Revision : 1.0 - initial release
// ============================================================================
module xgemac_rr_arb2 (
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic [1:0] grant_o
);

   always_comb begin
      grant_o = 2'b00;
      case (req_i)
         2'b01:   grant_o = 2'b01;
         2'b10:   grant_o = 2'b10;
         2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
         default: grant_o = 2'b00;
      endcase
   end

endmodule : xgemac_rr_arb2
`default_nettype wire

// File: rtl/xgemac_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : xgemac_wb_arbiter
// Purpose  : Shares one Wishbone master port to the XGEMAC register block
//            between two requesters. One bus cycle at a time, round-robin
//            arbitration, ack timeout with error response.
// Ports    : wb_clk_i / wb_rst_i       - clock, async active-low reset
//            req_valid/req_we [1:0]    - per-requester request and direction
//            req_addr/req_wdata        - packed per-requester address/data
//            req_ready [1:0]           - accept pulse to granted requester
//            rsp_valid [1:0]           - completion pulse to owner
//            rsp_rdata / rsp_err       - read data / timeout flag
//            wb_*_o                    - Wishbone master outputs
//            wb_ack_i / wb_dat_i       - Wishbone slave responses
// Revision : 1.0 - initial release
// ============================================================================
module xgemac_wb_arbiter
   import xgemac_wb_pkg::*;
#(
   parameter int ADDR_W  = WB_ADDR_WIDTH,
   parameter int DATA_W  = WB_DATA_WIDTH,
   parameter int TIMEOUT = WB_TIMEOUT
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic [1:0]          req_valid,
   input  logic [1:0]          req_we,
   input  logic [2*ADDR_W-1:0] req_addr,
   input  logic [2*DATA_W-1:0] req_wdata,
   output logic [1:0]          req_ready,
   output logic [1:0]          rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic [ADDR_W-1:0]   wb_adr_o,
   output logic [DATA_W-1:0]   wb_dat_o,
   output logic                wb_we_o,
   output logic                wb_cyc_o,
   output logic                wb_stb_o,
   input  logic                wb_ack_i,
   input  logic [DATA_W-1:0]   wb_dat_i
);

   localparam logic [WB_CNT_W-1:0] TMO_LAST = WB_CNT_W'(TIMEOUT - 1);

   wb_state_t           state_q, state_d;
   logic [WB_CNT_W-1:0] cnt_q, cnt_d;
   logic                last_q, last_d;
   logic                owner_q, owner_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   adr_q, adr_d;
   logic [DATA_W-1:0]   dat_q, dat_d;
   logic                cyc_q, cyc_d;
   logic [1:0]          rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;

   logic [1:0]          w_grant;
   logic [1:0]          w_ready;
   logic                w_idx;

   xgemac_rr_arb2 u_rr (
      .req_i   (req_valid),
      .last_i  (last_q),
      .grant_o (w_grant)
   );

   // The accept pulse is the only combinational output: it must appear in
   // the same cycle the request is sampled. Gating with reset keeps it low
   // while the block is held in reset.
   assign w_ready = (state_q == ST_IDLE && wb_rst_i) ? w_grant : 2'b00;
   assign w_idx   = w_grant[1];

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         last_q      <= 1'b1;   // requester 0 has priority after reset
         owner_q     <= 1'b0;
         we_q        <= 1'b0;
         adr_q       <= '0;
         dat_q       <= '0;
         cyc_q       <= 1'b0;
         rsp_valid_q <= 2'b00;
         rdata_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         owner_q     <= owner_d;
         we_q        <= we_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         cyc_q       <= cyc_d;
         rsp_valid_q <= rsp_valid_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      owner_d     = owner_q;
      we_d        = we_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      cyc_d       = 1'b0;
      // Response fields default to zero so they are single-cycle pulses.
      rsp_valid_d = 2'b00;
      rdata_d     = '0;
      err_d       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (|w_ready) begin
               state_d = ST_CYCLE;
               cyc_d   = 1'b1;
               cnt_d   = '0;
               owner_d = w_idx;
               last_d  = w_idx;
               we_d    = w_idx ? req_we[1] : req_we[0];
               adr_d   = w_idx ? req_addr[ADDR_W +: ADDR_W]
                               : req_addr[0 +: ADDR_W];
               dat_d   = w_idx ? req_wdata[DATA_W +: DATA_W]
                               : req_wdata[0 +: DATA_W];
            end
         end

         ST_CYCLE: begin
            cyc_d = 1'b1;
            // Ack takes precedence, so an ack arriving on the last allowed
            // count still completes normally.
            if (wb_ack_i) begin
               cyc_d       = 1'b0;
               state_d     = ST_RESP;
               rsp_valid_d = owner_q ? 2'b10 : 2'b01;
               rdata_d     = we_q ? '0 : wb_dat_i;
            end else if (cnt_q == TMO_LAST) begin
               cyc_d       = 1'b0;
               state_d     = ST_RESP;
               rsp_valid_d = owner_q ? 2'b10 : 2'b01;
               err_d       = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_RESP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign req_ready = w_ready;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign wb_adr_o  = adr_q;
   assign wb_dat_o  = dat_q;
   assign wb_we_o   = we_q;
   assign wb_cyc_o  = cyc_q;
   assign wb_stb_o  = cyc_q;

endmodule : xgemac_wb_arbiter
`default_nettype wire
